// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready request and result handshake.
// Ops 0-7 and undefined ops finish in one cycle. MUL, DIVU and REMU iterate
// one bit per cycle for WIDTH cycles on operands captured at acceptance.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Err
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] opa_r;      // MUL: shifting multiplicand; DIV: dividend shifting into quotient
  logic [WIDTH-1:0] opb_r;      // MUL: shifting multiplier;  DIV: divisor (held)
  logic [WIDTH-1:0] part_r;     // MUL: partial product;      DIV: partial remainder
  logic [SHW-1:0]   cnt_r;
  logic [WIDTH-1:0] result_r;
  logic             err_r;
  logic             out_valid_r;

  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] quick_res_s;
  logic             quick_err_s;
  logic             multi_s;

  logic [WIDTH:0]   rem_shift_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_rem_s;
  logic [WIDTH-1:0] div_quo_s;
  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH-1:0] next_part_s;
  logic [WIDTH-1:0] next_a_s;
  logic [WIDTH-1:0] next_b_s;
  logic [WIDTH-1:0] fin_res_s;
  logic             fin_err_s;

  assign in_ready  = rst_n & (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign Result    = result_r;
  assign Err       = err_r;
  assign Zero      = (result_r == '0);

  // Single-cycle result for ops 0-7 and undefined ops, straight from the request inputs.
  always_comb begin
    shamt_s     = B[SHW-1:0];
    quick_res_s = '0;
    quick_err_s = 1'b0;
    multi_s     = 1'b0;
    case (ALUOp)
      OP_ADD:  quick_res_s = A + B;
      OP_SUB:  quick_res_s = A - B;
      OP_AND:  quick_res_s = A & B;
      OP_OR:   quick_res_s = A | B;
      OP_XOR:  quick_res_s = A ^ B;
      OP_SLL:  quick_res_s = A << shamt_s;
      OP_SRL:  quick_res_s = A >> shamt_s;
      OP_SRA:  quick_res_s = WIDTH'($signed(A) >>> shamt_s);
      OP_MUL,
      OP_DIVU,
      OP_REMU: multi_s = 1'b1;
      default: begin
        quick_res_s = '0;
        quick_err_s = 1'b1;
      end
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide.
  // A zero divisor naturally yields an all-ones quotient and remainder = A.
  always_comb begin
    rem_shift_s = {part_r, opa_r[WIDTH-1]};
    div_ge_s    = (rem_shift_s >= {1'b0, opb_r});
    div_rem_s   = div_ge_s ? (rem_shift_s[WIDTH-1:0] - opb_r) : rem_shift_s[WIDTH-1:0];
    div_quo_s   = {opa_r[WIDTH-2:0], div_ge_s};
    mul_acc_s   = opb_r[0] ? (part_r + opa_r) : part_r;
    next_part_s = part_r;
    next_a_s    = opa_r;
    next_b_s    = opb_r;
    fin_res_s   = '0;
    fin_err_s   = 1'b0;
    if (op_r == OP_MUL) begin
      next_part_s = mul_acc_s;
      next_a_s    = {opa_r[WIDTH-2:0], 1'b0};
      next_b_s    = {1'b0, opb_r[WIDTH-1:1]};
      fin_res_s   = mul_acc_s;
      fin_err_s   = 1'b0;
    end else begin
      next_part_s = div_rem_s;
      next_a_s    = div_quo_s;
      next_b_s    = opb_r;
      fin_res_s   = (op_r == OP_REMU) ? div_rem_s : div_quo_s;
      fin_err_s   = (opb_r == '0);
    end
  end

  // Control FSM with registered result, error and valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= 4'd0;
      opa_r       <= '0;
      opb_r       <= '0;
      part_r      <= '0;
      cnt_r       <= '0;
      result_r    <= '0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r   <= ALUOp;
            opa_r  <= A;
            opb_r  <= B;
            part_r <= '0;
            cnt_r  <= '0;
            if (multi_s) begin
              state_r <= BUSY;
            end else begin
              state_r     <= DONE;
              result_r    <= quick_res_s;
              err_r       <= quick_err_s;
              out_valid_r <= 1'b1;
            end
          end
        end
        BUSY: begin
          part_r <= next_part_s;
          opa_r  <= next_a_s;
          opb_r  <= next_b_s;
          cnt_r  <= cnt_r + SHW'(1);
          if (cnt_r == LAST_CNT) begin
            state_r     <= DONE;
            result_r    <= fin_res_s;
            err_r       <= fin_err_s;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors for alu_mc (WIDTH=32) against a plain-arithmetic
// reference model; a single compare process checks every valid output cycle.
module tb_alu_mc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUOp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero;
  logic        Err;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_res;
  logic        exp_err;
  logic        armed;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Zero(Zero), .Err(Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: {err, result} from plain arithmetic.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    logic [63:0] prod;
    e = 1'b0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $signed(a) >>> b[4:0];
      4'd8: begin prod = 64'(a) * 64'(b); r = prod[31:0]; end
      4'd9: begin if (b == 32'd0) begin r = 32'hFFFF_FFFF; e = 1'b1; end else r = a / b; end
      4'd10: begin if (b == 32'd0) begin r = a; e = 1'b1; end else r = a % b; end
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  // Compare process: whenever a result is presented, it must match the model.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!armed) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        check("result", 64'(Result), 64'(exp_res));
        check("err", 64'(Err), 64'(exp_err));
        check("zero", 64'(Zero), 64'(exp_res == 32'd0));
      end
    end
  end

  // Issue one op starting at a negedge; returns at a negedge after consumption.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit_res, input logic lit_err,
                     input int hold, input bit keep_valid);
    logic [32:0] m;
    logic [31:0] held;
    int          n;
    int          lat;
    bit          rdy_seen;
    m = model(op, a, b);
    check("model_pin", 64'(m), 64'({lit_err, lit_res}));
    check("ready_idle", 64'(in_ready), 64'd1);
    exp_res   = m[31:0];
    exp_err   = m[32];
    armed     = 1'b1;
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    ALUOp     = op;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = keep_valid;
    A        = $urandom;
    B        = $urandom;
    ALUOp    = 4'($urandom_range(0, 7));
    lat      = (op >= 4'd8 && op <= 4'd10) ? 33 : 1;
    n        = 0;
    rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (in_ready) rdy_seen = 1'b1;
    end while (!out_valid && n < 100);
    in_valid = 1'b0;
    check("latency", 64'(n), 64'(lat));
    check("busy_ready_low", 64'(rdy_seen), 64'd0);
    if (hold > 0) begin
      held = Result;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("hold_result", 64'(Result), 64'(held));
        check("hold_ready", 64'(in_ready), 64'd0);
        check("hold_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("consumed", 64'(out_valid), 64'd0);
    check("ready_after", 64'(in_ready), 64'd1);
    armed     = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = 32'd0;
    B         = 32'd0;
    ALUOp     = 4'd0;
    out_ready = 1'b0;
    armed     = 1'b0;
    exp_res   = 32'd0;
    exp_err   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_zero", 64'(Zero), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(Result), 64'd0);
    check("rst_err", 64'(Err), 64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 64'(in_ready), 64'd1);
    @(negedge clk);

    run(4'd0,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 0, 1'b0);
    run(4'd7,  32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 0, 1'b0);
    run(4'd5,  32'd1,         32'd31,        32'h8000_0000, 1'b0, 0, 1'b0);
    run(4'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 0, 1'b0);
    run(4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 0, 1'b0);
    run(4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 0, 1'b0);
    run(4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 0, 1'b0);
    run(4'd6,  32'h8000_0000, 32'h1F,        32'd1,         1'b0, 0, 1'b0);
    run(4'd8,  32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0, 0, 1'b1);
    run(4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0, 0, 1'b0);
    run(4'd9,  32'd100,       32'd7,         32'd14,        1'b0, 0, 1'b0);
    run(4'd10, 32'd100,       32'd7,         32'd2,         1'b0, 0, 1'b0);
    run(4'd9,  32'd1234,      32'd0,         32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run(4'd10, 32'd5,         32'd0,         32'd5,         1'b1, 0, 1'b0);
    run(4'd0,  32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 5, 1'b0);
    run(4'd12, 32'hDEAD_BEEF, 32'h1,         32'd0,         1'b1, 5, 1'b0);
    run(4'd15, 32'd9,         32'd9,         32'd0,         1'b1, 0, 1'b0);

    // Reset in the middle of a DIVU aborts it with no result.
    in_valid  = 1'b1;
    A         = 32'd1000;
    B         = 32'd3;
    ALUOp     = 4'd9;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_result", 64'(Result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready_release", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    check("abort_no_result", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    run(4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 32, giving the operand and result width in bits (legal values 8..64, power of two).
REQ-002 The block SHALL have a localparam SHW = log2(WIDTH), giving the number of shift-amount bits taken from B.
REQ-003 Port clk SHALL be an input of 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n SHALL be an input of 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid SHALL be an input of 1 bit; when high, the operation request on A, B and ALUOp is valid.
REQ-006 Port in_ready SHALL be an output of 1 bit; when high, the block can accept a request.
REQ-007 Port A SHALL be an input of WIDTH bits, the first operand.
REQ-008 Port B SHALL be an input of WIDTH bits, the second operand.
REQ-009 Port ALUOp SHALL be an input of 4 bits, the operation select.
REQ-010 Port out_valid SHALL be an output of 1 bit; when high, Result, Zero and Err are valid.
REQ-011 Port out_ready SHALL be an input of 1 bit; when high, the consumer accepts the result.
REQ-012 Port Result SHALL be an output of WIDTH bits, the registered result.
REQ-013 Port Zero SHALL be an output of 1 bit, high when Result equals 0.
REQ-014 Port Err SHALL be an output of 1 bit, high on an undefined ALUOp or on divide-by-zero.

Function
REQ-015 ALUOp encoding SHALL be: 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 SLL by B[SHW-1:0]; 6 SRL; 7 SRA (signed A); 8 MUL (low WIDTH bits of unsigned A*B); 9 DIVU (A/B unsigned); 10 REMU (A%B unsigned); 11-15 undefined.
REQ-016 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH; no carry or overflow output is provided.
REQ-017 The FSM SHALL have states IDLE, BUSY and DONE; reset enters IDLE.
REQ-018 in_ready SHALL be high only in IDLE; a request is accepted when in_valid and in_ready are both high at a clock edge, and A, B and ALUOp are captured into internal registers at that edge.
REQ-019 On acceptance of ops 0-7 or 11-15, the FSM SHALL go IDLE->DONE, so out_valid is high on the cycle after acceptance (latency 1).
REQ-020 On acceptance of ops 8-10, the FSM SHALL go IDLE->BUSY and run an iterative shift-add multiply or restoring divide, one bit per cycle, for exactly WIDTH cycles, then go to DONE (latency WIDTH+1 cycles from acceptance to out_valid).
REQ-021 BUSY SHALL ignore in_valid; in_ready stays low.
REQ-022 In DONE, out_valid SHALL be high, and Result, Zero and Err SHALL hold stable until out_ready is high; on that edge the FSM goes DONE->IDLE (one idle bubble between results; maximum throughput is one op per 2 cycles for ops 0-7).
REQ-023 If out_ready is already high on entry to DONE, the result SHALL be consumed after one cycle of out_valid.
REQ-024 For an undefined op, Result SHALL be 0, Err SHALL be 1 and Zero SHALL be 1.
REQ-025 For divide-by-zero (B=0 with op 9 or 10), the op SHALL still take WIDTH+1 cycles; DIVU returns all-ones, REMU returns A, and Err is 1.
REQ-026 Err SHALL be 0 for all other operations.
REQ-027 Zero SHALL be derived from the registered Result and is meaningful only while out_valid is high.
REQ-028 Input changes outside the acceptance edge SHALL have no effect on an in-flight operation.

Reset
REQ-029 When rst_n is low, the block SHALL immediately (without a clock) force: state IDLE, out_valid 0, Result 0, Err 0, and the iteration counter and partial registers to 0.
REQ-030 During reset, Zero SHALL be 1 and in_ready SHALL be 0.
REQ-031 After reset is released, in_ready SHALL rise with IDLE on the first cycle, and the block accepts a request from the first clock edge after deassertion.
REQ-032 Reset asserted in BUSY or DONE SHALL abort the operation and discard the result; no out_valid follows.

Verification (WIDTH=32)
REQ-033 ADD of A=0xFFFFFFFF and B=1, with out_ready=1 -> out_valid one cycle after acceptance, Result=0, Zero=1, Err=0.
REQ-034 SRA of A=0x80000000 and B=0x24 (shift 4) -> Result=0xF8000000; SLL of A=1 and B=31 -> 0x80000000.
REQ-035 MUL of A=0x00010001 and B=0x00010001 -> out_valid exactly 33 cycles after acceptance, Result=0x00020001; in_valid held high throughout BUSY is not accepted.
REQ-036 DIVU of A=100 and B=7 -> Result 14; REMU -> 2; DIVU with B=0 -> Result 0xFFFFFFFF, Err=1; REMU of A=5 with B=0 -> Result 5, Err=1.
REQ-037 Backpressure: out_ready held 0 for 5 cycles in DONE -> Result stable and in_ready 0; ALUOp=12 -> Result 0, Err 1.
REQ-038 rst_n pulsed low at BUSY cycle 10 of a DIVU -> out_valid 0 immediately, in_ready 1 after release, and the next ADD of 2+3 returns 5.
